// File: rtl/fifo_rd_dispatch.sv
// Drains one packet from the FIFO picked by the select calculator onto a registered
// valid/ready stream, holding the request bits low until the calculator can re-arbitrate.
module fifo_rd_dispatch #(
    parameter int PORT_NUM    = 2,
    parameter int DATA_W      = 32,
    parameter int MAX_PKT_LEN = 256
) (
    input  logic                       glb_clk,
    input  logic                       glb_areset_n,
    input  logic [7:0]                 fifo_sel_code,
    output logic [PORT_NUM-1:0]        fifo_sel_bits,
    input  logic [PORT_NUM-1:0]        fifo_empty_n,
    input  logic [PORT_NUM*DATA_W-1:0] fifo_rd_data,
    input  logic [PORT_NUM-1:0]        fifo_rd_eop,
    output logic [PORT_NUM-1:0]        fifo_rd_en,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_sop,
    output logic                       out_eop,
    output logic [6:0]                 out_port,
    output logic                       busy,
    output logic                       err_bad_sel,
    output logic                       err_len
);

    localparam int CNT_W = $clog2(MAX_PKT_LEN + 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] XFER    = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;

    // Output stream: a word is transferred on a cycle where out_valid && out_ready;
    // out_valid never drops and the word never changes while out_valid && !out_ready.

    logic [1:0]          state;
    logic [6:0]          port_q;
    logic [CNT_W-1:0]    word_cnt;
    logic                first_q;

    logic [DATA_W-1:0]   head_data;
    logic                head_vld;
    logic                head_eop;
    logic [PORT_NUM-1:0] port_oh;
    logic                sel_ok;
    logic                load;
    logic                len_hit;

    always_comb begin
        head_data = '0;
        head_vld  = 1'b0;
        head_eop  = 1'b0;
        port_oh   = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            if (port_q == 7'(i)) begin
                head_data  = fifo_rd_data[i*DATA_W +: DATA_W];
                head_vld   = fifo_empty_n[i];
                head_eop   = fifo_rd_eop[i];
                port_oh[i] = 1'b1;
            end
        end
    end

    assign sel_ok  = fifo_sel_code[7] && (int'(fifo_sel_code[6:0]) < PORT_NUM);
    assign len_hit = (word_cnt == CNT_W'(MAX_PKT_LEN - 1));
    assign load    = glb_areset_n && (state == XFER) && head_vld && (!out_valid || out_ready);

    // Requests are masked during reset too, so the calculator sees nothing until IDLE is real.
    assign fifo_sel_bits = (glb_areset_n && state == IDLE) ? fifo_empty_n : '0;
    assign fifo_rd_en    = load ? port_oh : '0;
    assign busy          = (state != IDLE);

    always_ff @(posedge glb_clk) begin
        if (!glb_areset_n) begin
            state       <= IDLE;
            port_q      <= '0;
            word_cnt    <= '0;
            first_q     <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_sop     <= 1'b0;
            out_eop     <= 1'b0;
            out_port    <= '0;
            err_bad_sel <= 1'b0;
            err_len     <= 1'b0;
        end else begin
            err_bad_sel <= 1'b0;
            err_len     <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_ok) begin
                        port_q   <= fifo_sel_code[6:0];
                        word_cnt <= '0;
                        first_q  <= 1'b1;
                        state    <= XFER;
                    end else if (fifo_sel_code[7]) begin
                        err_bad_sel <= 1'b1;
                    end
                end
                XFER: begin
                    if (load) begin
                        word_cnt <= word_cnt + 1'b1;
                        first_q  <= 1'b0;
                        if (head_eop || len_hit) state <= RELEASE;
                        if (len_hit && !head_eop) err_len <= 1'b1;
                    end
                end
                RELEASE: state <= IDLE;
                default: state <= IDLE;
            endcase

            // The output stage drains on its own, independent of the FSM state.
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= head_data;
                out_sop   <= first_q;
                out_eop   <= head_eop || len_hit;
                out_port  <= port_q;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/fifo_rd_dispatch.md
Name: fifo_rd_dispatch

Overview:
- Downstream consumer of the FIFO-select calculator's 8-bit select code, where bit7 = valid and bits[6:0] = port index.
- On a valid code it latches the port and reads one packet from that input FIFO (show-ahead, one word per pop), with EOP flagging the last word.
- Presents the packet on a registered valid/ready output stream.
- Generates the request bits that feed the select calculator. It forces them low during a transfer so the calculator re-arbitrates cleanly afterwards.

Parameters:
- PORT_NUM, 2, number of input FIFOs (1..127).
- DATA_W, 32, data word width.
- MAX_PKT_LEN, 256, word-count limit per packet before forced termination (>=1).

Ports:
- glb_clk  input  1  single clock; all logic on rising edge.
- glb_areset_n  input  1  reset, synchronous, active-low.
- fifo_sel_code  input  8  select code from calculator; 8'h00 = none, 8'h80+n = port n.
- fifo_sel_bits  output  PORT_NUM  request bits to calculator, bit n = FIFO n has data.
- fifo_empty_n  input  PORT_NUM  per-FIFO not-empty; head word valid when high.
- fifo_rd_data  input  PORT_NUM*DATA_W  head words, port n at [n*DATA_W +: DATA_W].
- fifo_rd_eop  input  PORT_NUM  head word is last of packet.
- fifo_rd_en  output  PORT_NUM  one-hot pop strobe.
- out_valid  output  1  output word valid.
- out_ready  input  1  downstream accepts word.
- out_data  output  DATA_W  output word.
- out_sop  output  1  first word of packet.
- out_eop  output  1  last word of packet.
- out_port  output  7  source port of current word.
- busy  output  1  state != IDLE.
- err_bad_sel  output  1  one-cycle pulse: code bit7=1 with index >= PORT_NUM.
- err_len  output  1  one-cycle pulse: packet truncated at MAX_PKT_LEN.

Behaviour:
- Reset (glb_areset_n low at a clock edge): the following values are forced.
  - State IDLE.
  - out_valid, out_sop, out_eop = 0; out_data, out_port = 0.
  - Word counter = 0.
  - err_* = 0.
  - fifo_rd_en = 0, fifo_sel_bits = 0.
  - Reset is honoured mid-packet; the partial packet is abandoned with no EOP emitted.
- States: IDLE, XFER, RELEASE.
- IDLE:
  - fifo_sel_bits = fifo_empty_n.
  - If fifo_sel_code[7]=1 and index < PORT_NUM: latch the index, clear the word counter, set the first-word flag, and go to XFER next cycle.
  - If bit7=1 and index >= PORT_NUM: pulse err_bad_sel and stay IDLE.
  - Code 8'h00: stay IDLE.
- XFER:
  - fifo_sel_bits = 0; fifo_sel_code is ignored.
  - Load condition: fifo_empty_n[p] && (!out_valid || out_ready).
  - When the load condition holds, in the same cycle assert fifo_rd_en[p] and register the head word into the output stage.
  - out_sop = first-word flag; out_eop = fifo_rd_eop[p] or forced; out_port = p.
  - The counter increments per loaded word.
  - If the FIFO empties mid-packet, wait in XFER with no timeout.
- Forced EOP: when the loaded word is word number MAX_PKT_LEN and its fifo_rd_eop = 0, out_eop is forced to 1 and err_len pulses in the cycle after the load.
- Leaving XFER: loading any EOP word, real or forced, moves XFER to RELEASE.
- RELEASE:
  - One cycle; fifo_sel_bits = 0, no pops; then go to IDLE.
  - XFER + RELEASE guarantee at least 2 consecutive zero-request cycles, so the calculator's registered code returns to 8'h00 before the next grant.
- Output stage:
  - The output word holds stable while out_valid && !out_ready.
  - out_valid drops after acceptance if no new load occurs in that cycle.
  - Back-to-back loads give 1 word/clock throughput.
  - Leaving XFER does not clear a pending output word; it drains independently, including in IDLE.
- fifo_rd_en is never asserted in IDLE or RELEASE, and never for a port other than the latched one.
- Latency: valid code in IDLE at cycle t -> XFER at t+1 -> first word out_valid at t+2 (if FIFO non-empty and the output stage is free).

Test Plan:
- Reset: hold glb_areset_n=0 for 3 clocks, with FIFO 0 non-empty and code 8'h80 -> all outputs 0, fifo_sel_bits=0, no pops.
- Basic: FIFO 1 holds 4 words (A0..A3, EOP on A3), code 8'h81, out_ready=1 -> words out on 4 consecutive cycles starting t+2; out_sop on A0 only, out_eop on A3, out_port=1; fifo_sel_bits=0 for 5 cycles, then equals fifo_empty_n.
- Backpressure: out_ready=0 for 3 cycles mid-packet -> output word held stable, fifo_rd_en=0 during stall; no word lost or duplicated.
- Single-word packet on port 0 (EOP on first word) -> exactly one XFER and one RELEASE cycle; sel bits low 2 cycles; next code 8'h81 accepted in IDLE.
- Truncation: MAX_PKT_LEN=4, FIFO holds 6 words without EOP -> 4th word out with out_eop=1, err_len pulse; remaining 2 words start a new packet with out_sop=1 after re-selection.
- Bad select: code 8'h85 with PORT_NUM=2 -> err_bad_sel one-cycle pulse, no pops, state IDLE; reset asserted mid-XFER -> IDLE next cycle, out_valid=0.
